ram_burst_ctrl: RTL and testbench

Access controller that sits directly upstream of the single-port RAM and owns its we/addr/wr_data pins. It accepts single-beat writes and burst-read commands, and arbitrates them onto the one RAM port. Burst-read results are returned as a registered valid/ready stream with a last flag. It is the only RAM client, so it serialises all RAM traffic for the datapath.

---
 rtl/ram_burst_ctrl.sv | 133 +++++++++++++
 tb/tb_ram_burst_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_ctrl.sv
// Single-port RAM access controller: arbitrates single-beat writes against burst reads
// and returns read data as a registered valid/ready stream. Optional counters: RAM_BURST_CTRL_STATS_EN.
module ram_burst_ctrl #(
  parameter int RAM_ADDR_WIDTH = 8,
  parameter int RAM_DATA_WIDTH = 32,
  parameter int LEN_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_wr_valid,
  output logic                      o_wr_ready,
  input  logic [RAM_ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [RAM_DATA_WIDTH-1:0] i_wr_data,
  input  logic                      i_rd_cmd_valid,
  output logic                      o_rd_cmd_ready,
  input  logic [RAM_ADDR_WIDTH-1:0] i_rd_cmd_addr,
  input  logic [LEN_WIDTH-1:0]      i_rd_cmd_len,
  output logic                      o_rd_valid,
  input  logic                      i_rd_ready,
  output logic [RAM_DATA_WIDTH-1:0] o_rd_data,
  output logic                      o_rd_last,
  output logic                      o_busy,
`ifdef RAM_BURST_CTRL_STATS_EN
  output logic [15:0]               o_wr_beat_cnt,
  output logic [15:0]               o_rd_beat_cnt,
`endif
  output logic                      o_ram_we,
  output logic [RAM_ADDR_WIDTH-1:0] o_ram_addr,
  output logic [RAM_DATA_WIDTH-1:0] o_ram_wr_data,
  input  logic [RAM_DATA_WIDTH-1:0] i_ram_rd_data
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic GRANT_WR = 1'b0;
  localparam logic GRANT_RD = 1'b1;

  state_t                    state, next_state;
  logic [RAM_ADDR_WIDTH-1:0] rd_ptr;
  logic [LEN_WIDTH:0]        beats_left;
  logic                      last_grant;
  logic                      wr_grant, cmd_grant, fetch, handshake, final_beat;

  assign handshake  = o_rd_valid && i_rd_ready;
  assign final_beat = (beats_left == (LEN_WIDTH+1)'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Arbitration, RAM pin muxing and next-state selection
  always_comb begin
    next_state    = state;
    wr_grant      = 1'b0;
    cmd_grant     = 1'b0;
    fetch         = 1'b0;
    o_ram_we      = 1'b0;
    o_ram_addr    = rd_ptr;
    o_ram_wr_data = '0;
    case (state)
      IDLE: begin
        if (i_wr_valid && i_rd_cmd_valid) begin
          wr_grant  = (last_grant == GRANT_RD);
          cmd_grant = (last_grant == GRANT_WR);
        end else begin
          wr_grant  = i_wr_valid;
          cmd_grant = i_rd_cmd_valid;
        end
        if (wr_grant) begin
          o_ram_we      = 1'b1;
          o_ram_addr    = i_wr_addr;
          o_ram_wr_data = i_wr_data;
        end
        if (cmd_grant) next_state = READ;
      end
      READ: begin
        fetch = (beats_left != '0) && (!o_rd_valid || i_rd_ready);
        if (fetch && final_beat) next_state = DRAIN;
      end
      DRAIN: begin
        if (handshake) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign o_wr_ready     = wr_grant;
  assign o_rd_cmd_ready = cmd_grant;
  assign o_busy         = (state != IDLE);

  // Burst pointer/count and the registered read stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      beats_left <= '0;
      last_grant <= GRANT_RD;
      o_rd_valid <= 1'b0;
      o_rd_last  <= 1'b0;
      o_rd_data  <= '0;
    end else begin
      if (wr_grant) last_grant <= GRANT_WR;
      if (cmd_grant) begin
        last_grant <= GRANT_RD;
        rd_ptr     <= i_rd_cmd_addr;
        beats_left <= {1'b0, i_rd_cmd_len} + (LEN_WIDTH+1)'(1);
      end
      if (fetch) begin
        o_rd_data  <= i_ram_rd_data;
        o_rd_valid <= 1'b1;
        o_rd_last  <= final_beat;
        rd_ptr     <= rd_ptr + 1'b1;
        beats_left <= beats_left - (LEN_WIDTH+1)'(1);
      end else if (handshake) begin
        o_rd_valid <= 1'b0;
        o_rd_last  <= 1'b0;
      end
    end
  end

`ifdef RAM_BURST_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_wr_beat_cnt <= '0;
      o_rd_beat_cnt <= '0;
    end else begin
      if (wr_grant && o_wr_beat_cnt != 16'hFFFF)  o_wr_beat_cnt <= o_wr_beat_cnt + 16'd1;
      if (handshake && o_rd_beat_cnt != 16'hFFFF) o_rd_beat_cnt <= o_rd_beat_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl with a behavioural single-port RAM model.
module tb_ram_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_wr_valid, o_wr_ready;
  logic [7:0]  i_wr_addr;
  logic [31:0] i_wr_data;
  logic        i_rd_cmd_valid, o_rd_cmd_ready;
  logic [7:0]  i_rd_cmd_addr;
  logic [7:0]  i_rd_cmd_len;
  logic        o_rd_valid, i_rd_ready, o_rd_last, o_busy;
  logic [31:0] o_rd_data;
  logic        o_ram_we;
  logic [7:0]  o_ram_addr;
  logic [31:0] o_ram_wr_data, i_ram_rd_data;
`ifdef RAM_BURST_CTRL_STATS_EN
  logic [15:0] o_wr_beat_cnt, o_rd_beat_cnt;
`endif

  logic [31:0] mem [0:255];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign i_ram_rd_data = mem[o_ram_addr];
  always @(posedge clk) if (o_ram_we) mem[o_ram_addr] <= o_ram_wr_data;

  ram_burst_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_rd_cmd_valid(i_rd_cmd_valid), .o_rd_cmd_ready(o_rd_cmd_ready),
    .i_rd_cmd_addr(i_rd_cmd_addr), .i_rd_cmd_len(i_rd_cmd_len),
    .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready),
    .o_rd_data(o_rd_data), .o_rd_last(o_rd_last), .o_busy(o_busy),
`ifdef RAM_BURST_CTRL_STATS_EN
    .o_wr_beat_cnt(o_wr_beat_cnt), .o_rd_beat_cnt(o_rd_beat_cnt),
`endif
    .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
    .o_ram_wr_data(o_ram_wr_data), .i_ram_rd_data(i_ram_rd_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    i_wr_valid = 1'b1; i_wr_addr = a; i_wr_data = d;
    #1;
    chk("wr_ready", 32'(o_wr_ready), 32'd1);
    tick();
    i_wr_valid = 1'b0;
  endtask

  task automatic do_cmd(input logic [7:0] a, input logic [7:0] len);
    i_rd_cmd_valid = 1'b1; i_rd_cmd_addr = a; i_rd_cmd_len = len;
    #1;
    chk("cmd_ready", 32'(o_rd_cmd_ready), 32'd1);
    tick();
    i_rd_cmd_valid = 1'b0;
  endtask

  logic [31:0] exp_d [0:3];
  logic [31:0] prev_data;
  logic        prev_stall;
  int          idx;
  int          c;

  initial begin
    rst_n = 1'b0; i_wr_valid = 1'b0; i_wr_addr = '0; i_wr_data = '0;
    i_rd_cmd_valid = 1'b0; i_rd_cmd_addr = '0; i_rd_cmd_len = '0; i_rd_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(o_rd_valid), 32'd0);
    chk("rst_last", 32'(o_rd_last), 32'd0);
    chk("rst_data", o_rd_data, 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_we", 32'(o_ram_we), 32'd0);
    chk("rst_addr", 32'(o_ram_addr), 32'd0);
    chk("rst_wr_ready", 32'(o_wr_ready), 32'd0);
    chk("rst_cmd_ready", 32'(o_rd_cmd_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // single-beat burst and first-beat latency
    i_rd_ready = 1'b1;
    do_write(8'h10, 32'hDEADBEEF);
    do_cmd(8'h10, 8'd0);
    i_wr_valid = 1'b1;
    #1;
    chk("t1_wr_blocked", 32'(o_wr_ready), 32'd0);
    chk("t1_we_off", 32'(o_ram_we), 32'd0);
    chk("t1_n1_valid", 32'(o_rd_valid), 32'd0);
    chk("t1_busy", 32'(o_busy), 32'd1);
    chk("t1_ram_addr", 32'(o_ram_addr), 32'h10);
    i_wr_valid = 1'b0;
    tick();
    chk("t1_valid", 32'(o_rd_valid), 32'd1);
    chk("t1_data", o_rd_data, 32'hDEADBEEF);
    chk("t1_last", 32'(o_rd_last), 32'd1);
    tick();
    chk("t1_done_valid", 32'(o_rd_valid), 32'd0);
    chk("t1_done_busy", 32'(o_busy), 32'd0);

    // 8-beat streaming burst
    for (int k = 0; k < 8; k++) do_write(8'(k), 32'(k));
    do_cmd(8'h00, 8'd7);
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("t2_valid", 32'(o_rd_valid), 32'd1);
      chk("t2_data", o_rd_data, 32'(k));
      chk("t2_last", 32'(o_rd_last), 32'(k == 7));
      tick();
    end
    chk("t2_busy_after", 32'(o_busy), 32'd0);
    chk("t2_valid_after", 32'(o_rd_valid), 32'd0);

    // address wrap
    do_write(8'hFE, 32'hA0);
    do_write(8'hFF, 32'hA1);
    do_write(8'h00, 32'hA2);
    do_write(8'h01, 32'hA3);
    do_cmd(8'hFE, 8'd3);
    chk("t3_addr0", 32'(o_ram_addr), 32'hFE);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("t3_data", o_rd_data, 32'hA0 + 32'(k));
      chk("t3_last", 32'(o_rd_last), 32'(k == 3));
      tick();
    end
    chk("t3_busy_after", 32'(o_busy), 32'd0);

    // backpressure with ready pattern 1,0,0,1
    exp_d[0] = 32'd4; exp_d[1] = 32'd5; exp_d[2] = 32'd6; exp_d[3] = 32'd7;
    do_cmd(8'h04, 8'd3);
    idx = 0; c = 0; prev_stall = 1'b0; prev_data = '0;
    while (idx < 4 && c < 40) begin
      i_rd_ready = ((c % 4) == 0) || ((c % 4) == 3);
      #1;
      if (prev_stall) chk("t4_stall_hold", o_rd_data, prev_data);
      if (o_rd_valid) begin
        chk("t4_data", o_rd_data, exp_d[idx]);
        chk("t4_last", 32'(o_rd_last), 32'(idx == 3));
      end
      prev_stall = o_rd_valid && !i_rd_ready;
      prev_data  = o_rd_data;
      if (o_rd_valid && i_rd_ready) idx++;
      c++;
      tick();
    end
    chk("t4_beats", 32'(idx), 32'd4);
    chk("t4_valid_after", 32'(o_rd_valid), 32'd0);
    chk("t4_busy_after", 32'(o_busy), 32'd0);
    i_rd_ready = 1'b1;

    // arbitration from reset: write first, then alternate
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    i_wr_valid = 1'b1; i_wr_addr = 8'h20; i_wr_data = 32'h55;
    i_rd_cmd_valid = 1'b1; i_rd_cmd_addr = 8'h20; i_rd_cmd_len = 8'd0;
    #1;
    chk("t5_wr_first", 32'(o_wr_ready), 32'd1);
    chk("t5_cmd_wait", 32'(o_rd_cmd_ready), 32'd0);
    chk("t5_we", 32'(o_ram_we), 32'd1);
    tick();
    i_wr_valid = 1'b0;
    #1;
    chk("t5_cmd_next", 32'(o_rd_cmd_ready), 32'd1);
    tick();
    i_rd_cmd_valid = 1'b0;
    tick();
    chk("t5_raw_data", o_rd_data, 32'h55);
    tick();
    do_write(8'h21, 32'h66);
    i_wr_valid = 1'b1; i_wr_addr = 8'h22; i_wr_data = 32'h77;
    i_rd_cmd_valid = 1'b1; i_rd_cmd_addr = 8'h21; i_rd_cmd_len = 8'd0;
    #1;
    chk("t5_alt_cmd", 32'(o_rd_cmd_ready), 32'd1);
    chk("t5_alt_wr", 32'(o_wr_ready), 32'd0);
    chk("t5_alt_we", 32'(o_ram_we), 32'd0);
    tick();
    i_rd_cmd_valid = 1'b0;
    tick();
    chk("t5_alt_data", o_rd_data, 32'h66);
    tick();
    chk("t5_wr_after", 32'(o_wr_ready), 32'd1);
    tick();
    i_wr_valid = 1'b0;
    chk("t5_mem22", mem[8'h22], 32'h77);

    // reset during beat 2 of a 6-beat burst
    do_cmd(8'h00, 8'd5);
    repeat (3) tick();
    chk("t6_pre_valid", 32'(o_rd_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(o_rd_valid), 32'd0);
    chk("t6_rst_busy", 32'(o_busy), 32'd0);
    chk("t6_rst_last", 32'(o_rd_last), 32'd0);
`ifdef RAM_BURST_CTRL_STATS_EN
    chk("t6_wr_cnt", 32'(o_wr_beat_cnt), 32'd0);
    chk("t6_rd_cnt", 32'(o_rd_beat_cnt), 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_no_beats", 32'(o_rd_valid), 32'd0);
      chk("t6_idle", 32'(o_busy), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
